// File: rtl/usbdev_aon_suspend_seq_if.sv
// Sequencer-facing bundle: usbdev toggles, detector status/events, and outputs.
// The wake counter port exists only when USBDEV_AON_WAKE_CNT_EN is defined.
interface usbdev_aon_suspend_seq_if;
  logic       suspend_toggle_i;
  logic       wake_ack_toggle_i;
  logic       wake_detect_active_aon_i;
  logic       wake_req_aon_i;
  logic       bus_not_idle_aon_i;
  logic       bus_reset_aon_i;
  logic       sense_lost_aon_i;
  logic       suspend_req_aon_o;
  logic       wake_ack_aon_o;
  logic       powerdown_ok_aon_o;
  logic [2:0] wake_cause_aon_o;
  logic       arm_err_aon_o;
  logic [2:0] state_aon_o;
`ifdef USBDEV_AON_WAKE_CNT_EN
  logic [7:0] wake_count_aon_o;
`endif

  modport master (
    output suspend_toggle_i,
    output wake_ack_toggle_i,
    output wake_detect_active_aon_i,
    output wake_req_aon_i,
    output bus_not_idle_aon_i,
    output bus_reset_aon_i,
    output sense_lost_aon_i,
    input  suspend_req_aon_o,
    input  wake_ack_aon_o,
    input  powerdown_ok_aon_o,
    input  wake_cause_aon_o,
    input  arm_err_aon_o,
`ifdef USBDEV_AON_WAKE_CNT_EN
    input  wake_count_aon_o,
`endif
    input  state_aon_o
  );

  modport slave (
    input  suspend_toggle_i,
    input  wake_ack_toggle_i,
    input  wake_detect_active_aon_i,
    input  wake_req_aon_i,
    input  bus_not_idle_aon_i,
    input  bus_reset_aon_i,
    input  sense_lost_aon_i,
    output suspend_req_aon_o,
    output wake_ack_aon_o,
    output powerdown_ok_aon_o,
    output wake_cause_aon_o,
    output arm_err_aon_o,
`ifdef USBDEV_AON_WAKE_CNT_EN
    output wake_count_aon_o,
`endif
    output state_aon_o
  );
endinterface

// File: rtl/usbdev_aon_suspend_seq.sv
// AON suspend sequencer: toggle commands -> level requests to the wake detector.
// Define USBDEV_AON_WAKE_CNT_EN to add the saturating wake_count_aon_o counter.
module usbdev_aon_suspend_seq #(
  parameter int unsigned DwellCycles = 16,
  parameter int unsigned ArmTimeout  = 8
) (
  input logic                     clk_aon_i,
  input logic                     rst_aon_ni,
  usbdev_aon_suspend_seq_if.slave io
);

  localparam logic [15:0] DwellMax = 16'(DwellCycles);
  localparam logic [15:0] ArmMax   = 16'(ArmTimeout);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MONITOR = 3'd2,
    WOKEN   = 3'd3,
    RELEASE = 3'd4
  } state_e;

  logic [1:0]  susp_sync;
  logic [1:0]  ack_sync;
  logic        susp_q;
  logic        ack_q;
  logic        susp_pulse;
  logic        ack_pulse;

  state_e      state;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [15:0] dwell_nxt;
  logic [2:0]  evt;
  logic        susp_req_q;
  logic        wake_ack_q;
  logic        pd_ok_q;
  logic [2:0]  cause_q;
  logic        arm_err_q;
`ifdef USBDEV_AON_WAKE_CNT_EN
  logic [7:0]  wake_cnt_q;
`endif

  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      susp_sync <= '0;
      ack_sync  <= '0;
      susp_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      susp_sync <= {susp_sync[0], io.suspend_toggle_i};
      ack_sync  <= {ack_sync[0], io.wake_ack_toggle_i};
      susp_q    <= susp_sync[1];
      ack_q     <= ack_sync[1];
    end
  end

  // One-cycle command pulses; unused pulses are simply dropped.
  assign susp_pulse = susp_sync[1] ^ susp_q;
  assign ack_pulse  = ack_sync[1] ^ ack_q;

  assign evt = {io.sense_lost_aon_i,
                io.bus_reset_aon_i,
                io.bus_not_idle_aon_i};

  assign cnt_inc   = cnt + 16'd1;
  assign dwell_nxt = (cnt >= DwellMax) ? DwellMax : cnt_inc;

  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      susp_req_q <= 1'b0;
      wake_ack_q <= 1'b0;
      pd_ok_q    <= 1'b0;
      cause_q    <= '0;
      arm_err_q  <= 1'b0;
`ifdef USBDEV_AON_WAKE_CNT_EN
      wake_cnt_q <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (susp_pulse) begin
            state      <= ARM;
            cnt        <= '0;
            cause_q    <= '0;
            arm_err_q  <= 1'b0;
            susp_req_q <= 1'b1;
          end
        end
        ARM: begin
          if (io.wake_detect_active_aon_i) begin
            state <= MONITOR;
            cnt   <= '0;
          end else if (cnt_inc >= ArmMax) begin
            state      <= IDLE;
            arm_err_q  <= 1'b1;
            susp_req_q <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        MONITOR: begin
          // A wake on the dwell-completion cycle wins over powerdown.
          if (io.wake_req_aon_i) begin
            state      <= WOKEN;
            cause_q    <= cause_q | evt;
            susp_req_q <= 1'b0;
            pd_ok_q    <= 1'b0;
          end else if (ack_pulse) begin
            state      <= RELEASE;
            susp_req_q <= 1'b0;
            wake_ack_q <= 1'b1;
            pd_ok_q    <= 1'b0;
          end else begin
            cnt     <= dwell_nxt;
            pd_ok_q <= (dwell_nxt == DwellMax);
          end
        end
        WOKEN: begin
          cause_q <= cause_q | evt;
          if (ack_pulse) begin
            state      <= RELEASE;
            wake_ack_q <= 1'b1;
`ifdef USBDEV_AON_WAKE_CNT_EN
            if (wake_cnt_q != 8'hff) begin
              wake_cnt_q <= wake_cnt_q + 8'd1;
            end
`endif
          end
        end
        RELEASE: begin
          if (!io.wake_detect_active_aon_i) begin
            state      <= IDLE;
            wake_ack_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          susp_req_q <= 1'b0;
          wake_ack_q <= 1'b0;
          pd_ok_q    <= 1'b0;
          cause_q    <= '0;
          arm_err_q  <= 1'b0;
        end
      endcase
    end
  end

  assign io.suspend_req_aon_o  = susp_req_q;
  assign io.wake_ack_aon_o     = wake_ack_q;
  assign io.powerdown_ok_aon_o = pd_ok_q;
  assign io.wake_cause_aon_o   = cause_q;
  assign io.arm_err_aon_o      = arm_err_q;
  assign io.state_aon_o        = state;
`ifdef USBDEV_AON_WAKE_CNT_EN
  assign io.wake_count_aon_o   = wake_cnt_q;
`endif

`ifndef SYNTHESIS
  req_ack_excl_a: assert property (
    @(posedge clk_aon_i) disable iff (!rst_aon_ni)
    !(susp_req_q && wake_ack_q));
`endif

endmodule

// File: tb/tb_usbdev_aon_suspend_seq.sv
// Directed bench for usbdev_aon_suspend_seq with hand-computed expectations.
// Wake counter checks run only when USBDEV_AON_WAKE_CNT_EN is defined.
module tb_usbdev_aon_suspend_seq;
  logic clk;
  logic rst_n;
  int   errs;
  int   nchk;

  usbdev_aon_suspend_seq_if bus ();

  usbdev_aon_suspend_seq #(
    .DwellCycles(16),
    .ArmTimeout (8)
  ) dut (
    .clk_aon_i (clk),
    .rst_aon_ni(rst_n),
    .io        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [2:0] st,
                      input logic sr, input logic wa, input logic pd);
    chk({tag, ".state"}, 32'(bus.state_aon_o), 32'(st));
    chk({tag, ".sreq"}, 32'(bus.suspend_req_aon_o), 32'(sr));
    chk({tag, ".wack"}, 32'(bus.wake_ack_aon_o), 32'(wa));
    chk({tag, ".pdok"}, 32'(bus.powerdown_ok_aon_o), 32'(pd));
  endtask

  initial begin
    errs = 0;
    nchk = 0;
    rst_n = 1'b0;
    bus.suspend_toggle_i = 1'b0;
    bus.wake_ack_toggle_i = 1'b0;
    bus.wake_detect_active_aon_i = 1'b0;
    bus.wake_req_aon_i = 1'b0;
    bus.bus_not_idle_aon_i = 1'b0;
    bus.bus_reset_aon_i = 1'b0;
    bus.sense_lost_aon_i = 1'b0;
    tick(2);
    outs("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.cause", 32'(bus.wake_cause_aon_o), 32'd0);
    chk("rst.err", 32'(bus.arm_err_aon_o), 32'd0);
`ifdef USBDEV_AON_WAKE_CNT_EN
    chk("rst.wcnt", 32'(bus.wake_count_aon_o), 32'd0);
`endif
    rst_n = 1'b1;
    tick(1);

    // Suspend, activate two cycles into ARM, dwell to powerdown.
    bus.suspend_toggle_i = ~bus.suspend_toggle_i;
    tick(2);
    outs("s1.lat2", 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    outs("s1.arm", 3'd1, 1'b1, 1'b0, 1'b0);
    tick(2);
    bus.wake_detect_active_aon_i = 1'b1;
    tick(1);
    outs("s1.mon", 3'd2, 1'b1, 1'b0, 1'b0);
    tick(15);
    outs("s1.dw15", 3'd2, 1'b1, 1'b0, 1'b0);
    tick(1);
    outs("s1.dw16", 3'd2, 1'b1, 1'b0, 1'b1);
    tick(3);
    outs("s1.sat", 3'd2, 1'b1, 1'b0, 1'b1);

    // Wake with bus_not_idle, then sense_lost ORs in while WOKEN.
    bus.wake_req_aon_i = 1'b1;
    bus.bus_not_idle_aon_i = 1'b1;
    tick(1);
    outs("s1.woken", 3'd3, 1'b0, 1'b0, 1'b0);
    chk("s1.cause1", 32'(bus.wake_cause_aon_o), 32'd1);
    bus.wake_req_aon_i = 1'b0;
    bus.bus_not_idle_aon_i = 1'b0;
    bus.sense_lost_aon_i = 1'b1;
    tick(1);
    chk("s1.cause5", 32'(bus.wake_cause_aon_o), 32'd5);
    bus.sense_lost_aon_i = 1'b0;
    bus.suspend_toggle_i = ~bus.suspend_toggle_i;
    tick(4);
    outs("s1.ignsusp", 3'd3, 1'b0, 1'b0, 1'b0);
    bus.wake_ack_toggle_i = ~bus.wake_ack_toggle_i;
    tick(2);
    chk("s1.acklat", 32'(bus.state_aon_o), 32'd3);
    tick(1);
    outs("s1.rel", 3'd4, 1'b0, 1'b1, 1'b0);
    tick(3);
    outs("s1.relhold", 3'd4, 1'b0, 1'b1, 1'b0);
    bus.wake_detect_active_aon_i = 1'b0;
    tick(1);
    outs("s1.idle", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("s1.causehold", 32'(bus.wake_cause_aon_o), 32'd5);
`ifdef USBDEV_AON_WAKE_CNT_EN
    chk("s1.wcnt", 32'(bus.wake_count_aon_o), 32'd1);
`endif

    // Wake at dwell count 5 with bus_reset.
    bus.suspend_toggle_i = ~bus.suspend_toggle_i;
    bus.wake_detect_active_aon_i = 1'b1;
    tick(3);
    outs("s2.arm", 3'd1, 1'b1, 1'b0, 1'b0);
    chk("s2.clr", 32'(bus.wake_cause_aon_o), 32'd0);
    tick(1);
    outs("s2.mon", 3'd2, 1'b1, 1'b0, 1'b0);
    tick(5);
    bus.wake_req_aon_i = 1'b1;
    bus.bus_reset_aon_i = 1'b1;
    tick(1);
    outs("s2.woken", 3'd3, 1'b0, 1'b0, 1'b0);
    chk("s2.cause", 32'(bus.wake_cause_aon_o), 32'd2);
    bus.wake_req_aon_i = 1'b0;
    bus.bus_reset_aon_i = 1'b0;
    bus.wake_ack_toggle_i = ~bus.wake_ack_toggle_i;
    tick(3);
    outs("s2.rel", 3'd4, 1'b0, 1'b1, 1'b0);
    bus.wake_detect_active_aon_i = 1'b0;
    tick(1);
    outs("s2.idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // No activation: ARM times out after 8 cycles.
    bus.suspend_toggle_i = ~bus.suspend_toggle_i;
    tick(3);
    outs("s3.arm", 3'd1, 1'b1, 1'b0, 1'b0);
    tick(7);
    outs("s3.arm8", 3'd1, 1'b1, 1'b0, 1'b0);
    chk("s3.noerr", 32'(bus.arm_err_aon_o), 32'd0);
    tick(1);
    outs("s3.to", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("s3.err", 32'(bus.arm_err_aon_o), 32'd1);
    chk("s3.cause", 32'(bus.wake_cause_aon_o), 32'd0);
    bus.wake_ack_toggle_i = ~bus.wake_ack_toggle_i;
    tick(4);
    outs("s3.ackign", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("s3.errhold", 32'(bus.arm_err_aon_o), 32'd1);

    // Wake on the very cycle the dwell would complete.
    bus.suspend_toggle_i = ~bus.suspend_toggle_i;
    bus.wake_detect_active_aon_i = 1'b1;
    tick(3);
    chk("s4.errclr", 32'(bus.arm_err_aon_o), 32'd0);
    tick(1);
    outs("s4.mon", 3'd2, 1'b1, 1'b0, 1'b0);
    tick(15);
    outs("s4.dw15", 3'd2, 1'b1, 1'b0, 1'b0);
    bus.wake_req_aon_i = 1'b1;
    tick(1);
    outs("s4.woken", 3'd3, 1'b0, 1'b0, 1'b0);
    chk("s4.cause", 32'(bus.wake_cause_aon_o), 32'd0);
    bus.wake_req_aon_i = 1'b0;
    tick(2);
    outs("s4.nopd", 3'd3, 1'b0, 1'b0, 1'b0);
    bus.wake_ack_toggle_i = ~bus.wake_ack_toggle_i;
    tick(3);
    outs("s4.rel", 3'd4, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in RELEASE.
    #2;
    rst_n = 1'b0;
    bus.suspend_toggle_i = 1'b0;
    bus.wake_ack_toggle_i = 1'b0;
    #1;
    outs("s5.arst", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("s5.cause", 32'(bus.wake_cause_aon_o), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
`ifdef USBDEV_AON_WAKE_CNT_EN
    chk("s5.wcnt", 32'(bus.wake_count_aon_o), 32'd0);
`endif
    bus.wake_ack_toggle_i = ~bus.wake_ack_toggle_i;
    tick(5);
    outs("s5.ackonly", 3'd0, 1'b0, 1'b0, 1'b0);

    // Early resume from MONITOR by software.
    bus.suspend_toggle_i = ~bus.suspend_toggle_i;
    tick(4);
    outs("s6.mon", 3'd2, 1'b1, 1'b0, 1'b0);
    bus.wake_ack_toggle_i = ~bus.wake_ack_toggle_i;
    tick(3);
    outs("s6.rel", 3'd4, 1'b0, 1'b1, 1'b0);
    chk("s6.cause", 32'(bus.wake_cause_aon_o), 32'd0);
    bus.wake_detect_active_aon_i = 1'b0;
    tick(1);
    outs("s6.idle", 3'd0, 1'b0, 1'b0, 1'b0);

`ifdef USBDEV_AON_WAKE_CNT_EN
    chk("s7.wcnt0", 32'(bus.wake_count_aon_o), 32'd0);
    for (int i = 0; i < 300; i++) begin
      bus.suspend_toggle_i = ~bus.suspend_toggle_i;
      bus.wake_detect_active_aon_i = 1'b1;
      tick(4);
      bus.wake_req_aon_i = 1'b1;
      tick(1);
      bus.wake_req_aon_i = 1'b0;
      bus.wake_ack_toggle_i = ~bus.wake_ack_toggle_i;
      tick(3);
      bus.wake_detect_active_aon_i = 1'b0;
      tick(1);
      if (i == 0) chk("s7.wcnt1", 32'(bus.wake_count_aon_o), 32'd1);
    end
    outs("s7.idle", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("s7.wcnt255", 32'(bus.wake_count_aon_o), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/usbdev_aon_suspend_seq.md
Name: usbdev_aon_suspend_seq

Overview:
AON-domain sequencer directly upstream of the USB AON wake detector. It converts toggle-encoded suspend/wake-ack commands from the usbdev core into the level-held suspend_req_aon/wake_ack_aon signals the detector consumes. It tracks detector handshakes and enforces a minimum suspend dwell before granting powerdown. It also latches the wake cause for software readback after resume.

Parameters:
DwellCycles, 16, AON cycles in MONITOR before powerdown_ok_aon_o asserts; legal range 1..65535.
ArmTimeout, 8, AON cycles allowed in ARM for wake_detect_active to rise before arm_err is flagged; legal range 1..255.

Ports:
clk_aon_i  in  1  AON clock (~200 kHz)
rst_aon_ni  in  1  AON reset; asynchronous, active-low
suspend_toggle_i  in  1  toggle from usbdev clock domain; each edge = one suspend command; 2-flop synchronised internally
wake_ack_toggle_i  in  1  toggle from usbdev clock domain; each edge = one wake acknowledge; 2-flop synchronised internally
wake_detect_active_aon_i  in  1  detector state
wake_req_aon_i  in  1  detector wake request
bus_not_idle_aon_i  in  1  detector event
bus_reset_aon_i  in  1  detector event
sense_lost_aon_i  in  1  detector event
suspend_req_aon_o  out  1  to detector
wake_ack_aon_o  out  1  to detector
powerdown_ok_aon_o  out  1  dwell satisfied; safe to drop main power
wake_cause_aon_o  out  3  sticky {sense_lost, bus_reset, bus_not_idle}
arm_err_aon_o  out  1  sticky: detector failed to activate in time
state_aon_o  out  3  FSM state encoding, debug

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Sync flops and toggle-edge registers 0. Counter 0.
- Command pulse = synchronised toggle XOR its delayed copy. Latency from input toggle to pulse is 3 AON cycles.
- FSM encodings: IDLE=0, ARM=1, MONITOR=2, WOKEN=3, RELEASE=4. Other encodings return to IDLE next cycle with all outputs low.
- IDLE:
  - suspend pulse -> ARM. Clear wake_cause, arm_err and counter.
  - wake_ack pulse is ignored.
- ARM:
  - suspend_req_aon_o=1 (registered, asserted the cycle state==ARM).
  - wake_detect_active_aon_i=1 -> MONITOR, counter cleared.
  - Counter reaches ArmTimeout with no activation -> set arm_err, go to IDLE.
- MONITOR:
  - suspend_req_aon_o stays 1.
  - Counter increments, saturating at DwellCycles. powerdown_ok_aon_o=1 once counter==DwellCycles.
  - wake_req_aon_i=1 -> WOKEN. Capture wake_cause |= {sense_lost, bus_reset, bus_not_idle}. powerdown_ok drops the same cycle as the transition.
  - wake_req on the same cycle dwell completes: WOKEN wins, powerdown_ok stays 0.
  - wake_ack pulse in MONITOR (early resume by software) -> RELEASE, with wake_cause left 0.
- WOKEN:
  - suspend_req_aon_o=0.
  - Event inputs keep OR-ing into wake_cause while in this state.
  - wake_ack pulse -> RELEASE.
  - Additional suspend pulses are ignored.
- RELEASE:
  - wake_ack_aon_o=1 until wake_detect_active_aon_i=0, then IDLE.
- suspend_req_aon_o and wake_ack_aon_o are never 1 together.
- wake_cause and arm_err hold until the next suspend pulse accepted in IDLE.
- Toggle edges arriving in a state that ignores them are consumed, not queued.
- Async reset mid-sequence: all outputs drop to 0 immediately and the FSM returns to IDLE. There is no memory of a pending command.

Optional Feature:
USBDEV_AON_WAKE_CNT_EN
- Defined: adds output wake_count_aon_o [7:0]. It increments on every WOKEN->RELEASE transition, saturates at 255, and resets to 0 only on rst_aon_ni (not cleared by a new suspend).
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, flip suspend_toggle_i once, tie wake_detect_active=1 two cycles after suspend_req -> suspend_req_aon_o=1 3 cycles after the toggle; MONITOR reached; powerdown_ok=1 exactly 16 cycles later.
- In MONITOR at count 5, pulse wake_req with bus_reset=1 -> state WOKEN, wake_cause=3'b010, powerdown_ok=0; flip wake_ack_toggle_i -> wake_ack_aon_o=1 until active falls, then IDLE.
- Suspend with wake_detect_active held 0 -> arm_err=1 after 8 ARM cycles, FSM IDLE, suspend_req_aon_o=0.
- wake_req on the same cycle the count reaches 16 -> WOKEN, powerdown_ok never asserted.
- Assert rst_aon_ni low in RELEASE -> all outputs 0 asynchronously; after release, wake_ack toggle alone keeps the FSM in IDLE.
- With USBDEV_AON_WAKE_CNT_EN: 300 full suspend/wake cycles -> wake_count_aon_o=255.
